// File: rtl/pixel_array_ctrl.sv
// rtl/pixel_array_ctrl.sv - frame sequencer for the pixel sensor array
// Runs erase, expose and a 256-step conversion, then streams rows out over valid/ready.
module pixel_array_ctrl #(
  parameter int H        = 4,
  parameter int W        = 4,
  parameter int C_ERASE  = 5,
  parameter int C_EXPOSE = 255,
  localparam int RW      = (H > 1) ? $clog2(H) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               row_ready,
  input  logic [8*W*H-1:0]   DATA_IN,
  output logic               ERASE,
  output logic               EXPOSE,
  output logic               CONVERT,
  output logic [7:0]         CNT,
  output logic               CNT_OE,
  output logic [H-1:0]       READBUS,
  output logic [8*W-1:0]     row_data,
  output logic [RW-1:0]      row_idx,
  output logic               row_valid,
  output logic               frame_done,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONV, S_RSETTLE, S_RVALID
  } state_e;

  localparam logic [15:0]   ERASE_LAST  = 16'(C_ERASE - 1);
  localparam logic [15:0]   EXPOSE_LAST = 16'(C_EXPOSE - 1);
  localparam logic [RW-1:0] LAST_ROW    = RW'(H - 1);

  state_e           state_q, state_d;
  logic [15:0]      phase_q, phase_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [RW-1:0]    r_q, r_d;
  logic [8*W-1:0]   row_data_q, row_data_d;
  logic [RW-1:0]    row_idx_q, row_idx_d;
  logic             frame_done_q, frame_done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      cnt_q        <= '0;
      r_q          <= '0;
      row_data_q   <= '0;
      row_idx_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      r_q          <= r_d;
      row_data_q   <= row_data_d;
      row_idx_q    <= row_idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    r_d          = r_q;
    row_data_d   = row_data_q;
    row_idx_d    = row_idx_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ERASE;
          phase_d = '0;
        end
      end
      S_ERASE: begin
        if (phase_q == ERASE_LAST) begin
          state_d = S_EXPOSE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      S_EXPOSE: begin
        if (phase_q == EXPOSE_LAST) begin
          state_d = S_CONV;
          phase_d = '0;
          cnt_d   = '0;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      S_CONV: begin
        // The count saturates the phase; it is cleared on exit rather than wrapping.
        if (cnt_q == 8'hFF) begin
          state_d = S_RSETTLE;
          cnt_d   = '0;
          r_d     = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RSETTLE: begin
        row_data_d = DATA_IN[8*W*int'(r_q) +: 8*W];
        row_idx_d  = r_q;
        state_d    = S_RVALID;
      end
      S_RVALID: begin
        if (row_ready) begin
          if (r_q == LAST_ROW) begin
            state_d      = S_IDLE;
            r_d          = '0;
            frame_done_d = 1'b1;
          end else begin
            r_d     = r_q + RW'(1);
            state_d = S_RSETTLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode registered state only, so CNT_OE and READBUS can never overlap.
  always_comb begin
    ERASE      = 1'b0;
    EXPOSE     = 1'b0;
    CONVERT    = 1'b0;
    CNT_OE     = 1'b0;
    READBUS    = '0;
    row_valid  = 1'b0;
    busy       = (state_q != S_IDLE);
    CNT        = cnt_q;
    row_data   = row_data_q;
    row_idx    = row_idx_q;
    frame_done = frame_done_q;
    case (state_q)
      S_ERASE:   ERASE = 1'b1;
      S_EXPOSE:  EXPOSE = 1'b1;
      S_CONV: begin
        CONVERT = 1'b1;
        CNT_OE  = 1'b1;
      end
      S_RSETTLE: READBUS = H'(1) << r_q;
      S_RVALID: begin
        READBUS   = H'(1) << r_q;
        row_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// tb/tb_pixel_array_ctrl.sv - self-checking bench for pixel_array_ctrl
// Table-driven frames with a row scoreboard, plus reset, start and random-stall sequences.
module tb_pixel_array_ctrl;
  localparam int H    = 2;
  localparam int W    = 4;
  localparam int CE   = 3;
  localparam int CX   = 10;
  localparam int RW   = 1;
  localparam int BASE = CE + CX + 256 + 2 * H;

  logic             clk;
  logic             reset;
  logic             start;
  logic             row_ready;
  logic [8*W*H-1:0] DATA_IN;
  logic             ERASE, EXPOSE, CONVERT, CNT_OE, row_valid, frame_done, busy;
  logic [7:0]       CNT;
  logic [H-1:0]     READBUS;
  logic [8*W-1:0]   row_data;
  logic [RW-1:0]    row_idx;

  pixel_array_ctrl #(.H(H), .W(W), .C_ERASE(CE), .C_EXPOSE(CX)) dut (
    .clk(clk), .reset(reset), .start(start), .row_ready(row_ready), .DATA_IN(DATA_IN),
    .ERASE(ERASE), .EXPOSE(EXPOSE), .CONVERT(CONVERT), .CNT(CNT), .CNT_OE(CNT_OE),
    .READBUS(READBUS), .row_data(row_data), .row_idx(row_idx), .row_valid(row_valid),
    .frame_done(frame_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] data;
    logic [31:0] row0;
    logic [31:0] row1;
    int          stall0;
    int          stall1;
    bit          start_mid;
    int          exp_len;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [0:0]  idx;
  } row_t;

  row_t sb[$];
  vec_t vecs[4];

  task automatic check_all_zero(input string name);
    check(name, {ERASE, EXPOSE, CONVERT, CNT, CNT_OE, READBUS, row_data, row_idx,
                 row_valid, frame_done, busy}, 64'd0);
  endtask

  // Called right after a negedge; returns at a negedge.
  task automatic run_frame(input logic [63:0] data, input logic [31:0] r0, input logic [31:0] r1,
                           input int s0, input int s1, input bit start_mid, input bit rand_ready,
                           input bit launched, input bit hold_end, input int exp_len);
    int cycles, er, ex, rb0, rb1, exp_cnt, cnt_err, stalls;
    int stall_left[2];
    DATA_IN = data;
    sb.push_back('{r0, 1'b0});
    sb.push_back('{r1, 1'b1});
    if (!launched) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    check("start_latency", {ERASE, busy}, 2'b11);
    cycles = 0; er = 0; ex = 0; rb0 = 0; rb1 = 0; exp_cnt = 0; cnt_err = 0; stalls = 0;
    stall_left[0] = s0;
    stall_left[1] = s1;
    while (busy && cycles < 2000) begin
      cycles++;
      er += int'(ERASE);
      ex += int'(EXPOSE);
      check("bus_exclusive", CNT_OE & (|READBUS), 1'b0);
      check("readbus_onehot", $countones(READBUS) <= 1, 1'b1);
      if (CNT_OE) begin
        if (CNT !== exp_cnt[7:0]) cnt_err++;
        exp_cnt++;
      end
      if (READBUS == 2'b01) rb0++;
      if (READBUS == 2'b10) rb1++;
      start = start_mid && EXPOSE && (ex == 5);
      row_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (row_valid) begin
        if (sb.size() == 0) begin
          check("sb_empty_on_valid", 64'd1, 64'd0);
        end else begin
          check("row_data", row_data, sb[0].data);
          check("row_idx", row_idx, sb[0].idx);
          check("readbus_row", READBUS, 2'b01 << sb[0].idx);
          if (!rand_ready) begin
            row_ready = (stall_left[sb[0].idx] == 0);
            if (!row_ready) stall_left[sb[0].idx]--;
          end
          if (!row_ready) stalls++;
          else begin
            void'(sb.pop_front());
            if (hold_end && sb.size() == 0) start = 1'b1;
          end
        end
      end
      @(negedge clk);
    end
    check("frame_ends", busy, 1'b0);
    check("frame_done_pulse", frame_done, 1'b1);
    check("row_valid_low", row_valid, 1'b0);
    check("frame_len", cycles, (exp_len < 0) ? BASE + stalls : exp_len);
    check("erase_len", er, CE);
    check("expose_len", ex, CX);
    check("cnt_steps", exp_cnt, 256);
    check("cnt_values", cnt_err, 0);
    check("rows_drained", sb.size(), 0);
    if (!rand_ready) begin
      check("readbus_row0_len", rb0, 2 + s0);
      check("readbus_row1_len", rb1, 2 + s1);
    end
    sb.delete();
    if (hold_end) begin
      @(negedge clk);
      check("restart_erase", {ERASE, busy, frame_done}, 3'b110);
      start = 1'b0;
    end else begin
      @(negedge clk);
      check("frame_done_one_cycle", {frame_done, busy}, 2'b00);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    int          waited;
    vecs[0] = '{64'h88776655_44332211, 32'h44332211, 32'h88776655, 0, 0, 1'b0, BASE};
    vecs[1] = '{64'hDEADBEEF_0BADF00D, 32'h0BADF00D, 32'hDEADBEEF, 7, 0, 1'b0, BASE + 7};
    vecs[2] = '{64'h00000000_FFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 3, 1'b0, BASE + 3};
    vecs[3] = '{64'h12345678_A5A55A5A, 32'hA5A55A5A, 32'h12345678, 2, 2, 1'b1, BASE + 4};

    reset = 1'b1; start = 1'b0; row_ready = 1'b0; DATA_IN = '0;
    #1;
    check_all_zero("reset_outputs");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", busy, 1'b0);

    for (int i = 0; i < 4; i++)
      run_frame(vecs[i].data, vecs[i].row0, vecs[i].row1, vecs[i].stall0, vecs[i].stall1,
                vecs[i].start_mid, 1'b0, 1'b0, 1'b0, vecs[i].exp_len);

    // Start held through frame_done chains straight into the next frame.
    start = 1'b0;
    @(negedge clk);
    run_frame(vecs[0].data, vecs[0].row0, vecs[0].row1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, BASE);
    run_frame(vecs[1].data, vecs[1].row0, vecs[1].row1, 1, 1, 1'b0, 1'b0, 1'b1, 1'b0, BASE + 2);

    // Asynchronous reset in the middle of conversion.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (CNT != 8'd100 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check("reach_cnt100", {CONVERT, CNT}, {1'b1, 8'd100});
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset_mid_conv");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_mid_reset", {busy, CONVERT, CNT}, 10'd0);
    run_frame(vecs[0].data, vecs[0].row0, vecs[0].row1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, BASE);

    for (int f = 0; f < 20; f++) begin
      d = {$urandom, $urandom};
      run_frame(d, d[31:0], d[63:32], 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
